multicycle_ctrl: RTL and testbench

MULTICYCLE_CTRL -- requirements
Module: multicycle_ctrl

---
 rtl/multicycle_ctrl.sv | 232 +++++++++++++++++++++++
 tb/tb_multicycle_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl -- control FSM for a multicycle datapath.
// Sequences FETCH -> DECODE -> EXEC -> (MEM) -> (WB) and drives the datapath
// selects/enables. Memory waits are bounded by a timeout that ends in TRAP.
// Instruction encoding (op = instr[W-1:W-2], func = instr[W-3:W-5]):
//   op 00: func 000 ADD, 001 SUB, 010 AND, 011 OR, 100 SLT (else illegal)
//   op 01: func 000 ADDI, 001 LOAD, 011 STOR, 100 LUI (else illegal)
//   op 10: JAL (any func)    op 11: BEQ (any func)
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   instr_i             instruction word, valid with imem_ack_i
//   imem_ack_i          instruction memory ack
//   dmem_ack_i          data memory ack
//   alu_eq_i            ALU equal flag (BEQ)
//   imem_req_o          instruction fetch request
//   dmem_req_o/_we_o    data memory request / write enable (STOR)
//   ir_load_o           load instruction register
//   pc_write_o, pc_s_o  PC update enable and source (0 INC, 1 ADD)
//   rf_we_o, data_s_o   register write enable and one-hot write-data select
//   alu_func_o          0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 GT,6 ET
//   operand_s_o         0 NOP,1 RY,2 KK,3 SHIFTED
//   trap_o              sticky fault flag
//   retired_o           retired-instruction counter (wraps)
module multicycle_ctrl #(
    parameter int INSTR_W         = 16,
    parameter int TIMEOUT         = 15,
    parameter int TRAP_ON_ILLEGAL = 1,
    parameter int CNT_W           = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               imem_ack_i,
    input  logic               dmem_ack_i,
    input  logic               alu_eq_i,
    output logic               imem_req_o,
    output logic               dmem_req_o,
    output logic               dmem_we_o,
    output logic               ir_load_o,
    output logic               pc_write_o,
    output logic               rf_we_o,
    output logic [2:0]         alu_func_o,
    output logic               pc_s_o,
    output logic [1:0]         operand_s_o,
    output logic [3:0]         data_s_o,
    output logic               trap_o,
    output logic [CNT_W-1:0]   retired_o
);
    typedef enum logic [2:0] {FETCH, DECODE, EXEC, MEM, WB, TRAP} state_t;
    typedef enum logic [2:0] {ALU_NOP, ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_GT, ALU_ET} alu_func_t;
    typedef enum logic [1:0] {OPERAND_NOP, OPERAND_RY, OPERAND_KK, OPERAND_SHIFTED} operand_s_t;
    typedef enum logic {PC_INC, PC_ADD} pc_s_t;
    typedef enum logic [3:0] {DATA_NOP = 4'b0000, DATA_ALU = 4'b0001,
                              DATA_WORD = 4'b0010, DATA_PC = 4'b0100} data_s_t;
    typedef enum logic [2:0] {C_RR, C_ADDI, C_LUI, C_LOAD, C_STOR, C_JAL, C_BEQ, C_ILL} cls_t;

    // Counter only needs to reach TIMEOUT-1: the limit is detected one step early.
    localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    state_t           state_q, state_d;
    logic [TO_W-1:0]  cnt_q, cnt_d;
    logic [4:0]       ir_q;        // op+func latched on fetch ack
    logic [CNT_W-1:0] retired_q;
    logic             retire;
    logic [1:0]       op;
    logic [2:0]       fn;
    cls_t             cls;
    alu_func_t        ex_alu;
    operand_s_t       ex_opd;
    logic             timed_out;
    logic             unused_instr;

    assign unused_instr = ^instr_i[INSTR_W-6:0];
    assign op = ir_q[4:3];
    assign fn = ir_q[2:0];
    assign timed_out = (TIMEOUT != 0) && (cnt_q == TO_LAST);

    always_comb begin
        cls = C_ILL;
        case (op)
            2'b00: if (fn <= 3'd4) cls = C_RR;
            2'b01: begin
                case (fn)
                    3'd0:    cls = C_ADDI;
                    3'd1:    cls = C_LOAD;
                    3'd3:    cls = C_STOR;
                    3'd4:    cls = C_LUI;
                    default: cls = C_ILL;
                endcase
            end
            2'b10:   cls = C_JAL;
            default: cls = C_BEQ;
        endcase
    end

    // ALU/operand selects chosen in EXEC; MEM and WB keep driving them.
    always_comb begin
        ex_alu = ALU_NOP;
        ex_opd = OPERAND_NOP;
        case (cls)
            C_RR: begin
                ex_opd = OPERAND_RY;
                case (fn)
                    3'd0:    ex_alu = ALU_ADD;
                    3'd1:    ex_alu = ALU_SUB;
                    3'd2:    ex_alu = ALU_AND;
                    3'd3:    ex_alu = ALU_OR;
                    default: ex_alu = ALU_GT;
                endcase
            end
            C_ADDI, C_LOAD, C_STOR: begin
                ex_alu = ALU_ADD;
                ex_opd = OPERAND_KK;
            end
            C_LUI: ex_opd = OPERAND_SHIFTED;
            C_BEQ: begin
                ex_alu = ALU_ET;
                ex_opd = OPERAND_RY;
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = '0;
        retire      = 1'b0;
        imem_req_o  = 1'b0;
        dmem_req_o  = 1'b0;
        dmem_we_o   = 1'b0;
        ir_load_o   = 1'b0;
        pc_write_o  = 1'b0;
        rf_we_o     = 1'b0;
        alu_func_o  = ALU_NOP;
        pc_s_o      = PC_INC;
        operand_s_o = OPERAND_NOP;
        data_s_o    = DATA_NOP;
        trap_o      = 1'b0;
        case (state_q)
            FETCH: begin
                imem_req_o = 1'b1;
                if (imem_ack_i) begin
                    ir_load_o = 1'b1;
                    state_d   = DECODE;
                end else if (timed_out) begin
                    state_d = TRAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DECODE: begin
                if (cls != C_ILL) begin
                    state_d = EXEC;
                end else if (TRAP_ON_ILLEGAL != 0) begin
                    state_d = TRAP;
                end else begin
                    pc_write_o = 1'b1;
                    retire     = 1'b1;
                    state_d    = FETCH;
                end
            end
            // Memory ops issue their request already in EXEC so a zero-wait
            // ack skips MEM entirely; MEM starts its own timeout window.
            EXEC, MEM: begin
                alu_func_o  = ex_alu;
                operand_s_o = ex_opd;
                case (cls)
                    C_LOAD, C_STOR: begin
                        dmem_req_o = 1'b1;
                        dmem_we_o  = (cls == C_STOR);
                        if (dmem_ack_i) begin
                            if (cls == C_LOAD) begin
                                state_d = WB;
                            end else begin
                                pc_write_o = 1'b1;
                                retire     = 1'b1;
                                state_d    = FETCH;
                            end
                        end else if (state_q == EXEC) begin
                            state_d = MEM;
                        end else if (timed_out) begin
                            state_d = TRAP;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                    C_JAL: begin
                        rf_we_o    = 1'b1;
                        data_s_o   = DATA_PC;
                        pc_write_o = 1'b1;
                        pc_s_o     = PC_ADD;
                        retire     = 1'b1;
                        state_d    = FETCH;
                    end
                    C_BEQ: begin
                        pc_write_o = 1'b1;
                        pc_s_o     = alu_eq_i ? PC_ADD : PC_INC;
                        retire     = 1'b1;
                        state_d    = FETCH;
                    end
                    default: state_d = WB;
                endcase
            end
            WB: begin
                alu_func_o  = ex_alu;
                operand_s_o = ex_opd;
                rf_we_o     = 1'b1;
                pc_write_o  = 1'b1;
                data_s_o    = (cls == C_LOAD) ? DATA_WORD : DATA_ALU;
                retire      = 1'b1;
                state_d     = FETCH;
            end
            default: trap_o = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= FETCH;
            cnt_q     <= '0;
            ir_q      <= '0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (state_q == FETCH && imem_ack_i) ir_q <= instr_i[INSTR_W-1 -: 5];
            if (retire) retired_q <= retired_q + 1'b1;
        end
    end

    assign retired_o = retired_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: per instruction a list of cycles (inputs plus
// expected outputs) is derived from the controller's behavioural rules, then
// replayed against the DUT. Two instances cover both illegal-op policies.
module tb_multicycle_ctrl;
    localparam int W = 16;
    localparam int CW = 4;
    localparam int TMO = 15;
    localparam logic [2:0] A_NOP = 3'd0, A_ADD = 3'd1, A_SUB = 3'd2, A_AND = 3'd3,
                           A_OR = 3'd4, A_GT = 3'd5, A_ET = 3'd6;
    localparam logic [1:0] O_NOP = 2'd0, O_RY = 2'd1, O_KK = 2'd2, O_SH = 2'd3;
    localparam logic [3:0] D_NOP = 4'b0000, D_ALU = 4'b0001, D_WORD = 4'b0010, D_PC = 4'b0100;

    logic clk = 1'b0, rst = 1'b1;
    always #5 clk = ~clk;

    logic [W-1:0] a_instr = '0, b_instr = '0;
    logic a_iack = 0, a_dack = 0, a_eq = 0, b_iack = 0, b_dack = 0, b_eq = 0;
    logic a_ireq, a_dreq, a_we, a_ir, a_pcw, a_rfw, a_pcs, a_trap;
    logic b_ireq, b_dreq, b_we, b_ir, b_pcw, b_rfw, b_pcs, b_trap;
    logic [2:0] a_alu, b_alu;
    logic [1:0] a_opd, b_opd;
    logic [3:0] a_ds, b_ds;
    logic [CW-1:0] a_ret, b_ret;

    multicycle_ctrl #(.INSTR_W(W), .TIMEOUT(TMO), .TRAP_ON_ILLEGAL(1), .CNT_W(CW)) dut_a (
        .clk(clk), .rst(rst), .instr_i(a_instr), .imem_ack_i(a_iack), .dmem_ack_i(a_dack),
        .alu_eq_i(a_eq), .imem_req_o(a_ireq), .dmem_req_o(a_dreq), .dmem_we_o(a_we),
        .ir_load_o(a_ir), .pc_write_o(a_pcw), .rf_we_o(a_rfw), .alu_func_o(a_alu),
        .pc_s_o(a_pcs), .operand_s_o(a_opd), .data_s_o(a_ds), .trap_o(a_trap), .retired_o(a_ret));

    multicycle_ctrl #(.INSTR_W(W), .TIMEOUT(TMO), .TRAP_ON_ILLEGAL(0), .CNT_W(CW)) dut_b (
        .clk(clk), .rst(rst), .instr_i(b_instr), .imem_ack_i(b_iack), .dmem_ack_i(b_dack),
        .alu_eq_i(b_eq), .imem_req_o(b_ireq), .dmem_req_o(b_dreq), .dmem_we_o(b_we),
        .ir_load_o(b_ir), .pc_write_o(b_pcw), .rf_we_o(b_rfw), .alu_func_o(b_alu),
        .pc_s_o(b_pcs), .operand_s_o(b_opd), .data_s_o(b_ds), .trap_o(b_trap), .retired_o(b_ret));

    wire [16:0] oa = {a_ireq, a_dreq, a_we, a_ir, a_pcw, a_rfw, a_alu, a_pcs, a_opd, a_ds, a_trap};
    wire [16:0] ob = {b_ireq, b_dreq, b_we, b_ir, b_pcw, b_rfw, b_alu, b_pcs, b_opd, b_ds, b_trap};

    typedef struct {
        logic         iack, dack, eq;
        logic [W-1:0] instr;
        logic [16:0]  exp;
    } ent_t;
    ent_t tr[$];

    int n_vec = 0, n_err = 0;
    logic [CW-1:0] ret_a = '0, ret_b = '0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [16:0] pk(input logic ireq, dreq, we, ir, pcw, rfw,
                                       input logic [2:0] alu, input logic pcs,
                                       input logic [1:0] opd, input logic [3:0] ds,
                                       input logic trap);
        return {ireq, dreq, we, ir, pcw, rfw, alu, pcs, opd, ds, trap};
    endfunction

    function automatic logic [16:0] idle();
        return pk(0, 0, 0, 0, 0, 0, A_NOP, 0, O_NOP, D_NOP, 0);
    endfunction

    task automatic add(input logic iack, dack, eq, input logic [W-1:0] ins, input logic [16:0] exp);
        ent_t e;
        e.iack = iack; e.dack = dack; e.eq = eq; e.instr = ins; e.exp = exp;
        tr.push_back(e);
    endtask

    task automatic add_trap();
        for (int i = 0; i < 3; i++)
            add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), pk(0,0,0,0,0,0,A_NOP,0,O_NOP,D_NOP,1));
    endtask

    // Expected cycle list for one instruction. wi/wd = wait cycles before ack.
    task automatic build(input logic [1:0] op, input logic [2:0] fn, input int wi, input int wd,
                         input logic eq, input bit trap_ill, output bit ret, output bit trapped);
        logic [W-1:0] ins;
        logic [2:0] alu;
        logic [1:0] opd;
        bit legal, is_mem, stor;
        ins = {op, fn, 11'($urandom)};
        ret = 0; trapped = 0;
        tr.delete();
        if (wi >= TMO) begin
            for (int i = 0; i < TMO; i++)
                add(0, 1'($urandom), 1'($urandom), W'($urandom), pk(1,0,0,0,0,0,A_NOP,0,O_NOP,D_NOP,0));
            add_trap(); trapped = 1; return;
        end
        for (int i = 0; i < wi; i++)
            add(0, 1'($urandom), 1'($urandom), W'($urandom), pk(1,0,0,0,0,0,A_NOP,0,O_NOP,D_NOP,0));
        add(1, 1'($urandom), 1'($urandom), ins, pk(1,0,0,1,0,0,A_NOP,0,O_NOP,D_NOP,0));
        legal = op[1] || (op == 2'd0 && fn <= 3'd4) ||
                (op == 2'd1 && (fn == 3'd0 || fn == 3'd1 || fn == 3'd3 || fn == 3'd4));
        if (!legal) begin
            if (trap_ill) begin
                add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), idle());
                add_trap(); trapped = 1;
            end else begin
                add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
                    pk(0,0,0,0,1,0,A_NOP,0,O_NOP,D_NOP,0));
                ret = 1;
            end
            return;
        end
        add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), idle());
        if (op == 2'd2) begin
            add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), pk(0,0,0,0,1,1,A_NOP,1,O_NOP,D_PC,0));
            ret = 1; return;
        end
        if (op == 2'd3) begin
            add(1'($urandom), 1'($urandom), eq, W'($urandom), pk(0,0,0,0,1,0,A_ET,eq,O_RY,D_NOP,0));
            ret = 1; return;
        end
        alu = A_ADD; opd = O_KK;
        if (op == 2'd0) begin
            opd = O_RY;
            case (fn)
                3'd0: alu = A_ADD;
                3'd1: alu = A_SUB;
                3'd2: alu = A_AND;
                3'd3: alu = A_OR;
                default: alu = A_GT;
            endcase
        end else if (fn == 3'd4) begin
            alu = A_NOP; opd = O_SH;
        end
        is_mem = (op == 2'd1) && (fn == 3'd1 || fn == 3'd3);
        stor = is_mem && fn == 3'd3;
        if (is_mem) begin
            // request cycle 0 is EXEC, 1..TMO are MEM; no ack by MEM cycle TMO -> TRAP
            for (int k = 0; k <= TMO; k++) begin
                bit ack;
                ack = (k == wd);
                add(1'($urandom), ack, 1'($urandom), W'($urandom),
                    pk(0,1,stor,0,ack && stor,0,alu,0,opd,D_NOP,0));
                if (ack) break;
            end
            if (wd > TMO) begin add_trap(); trapped = 1; return; end
            if (stor) begin ret = 1; return; end
        end else begin
            add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom), pk(0,0,0,0,0,0,alu,0,opd,D_NOP,0));
        end
        add(1'($urandom), 1'($urandom), 1'($urandom), W'($urandom),
            pk(0,0,0,0,1,1,alu,0,opd,is_mem ? D_WORD : D_ALU,0));
        ret = 1;
    endtask

    task automatic play(input bit which, input int lim, input string tag);
        for (int k = 0; k < tr.size() && k < lim; k++) begin
            @(negedge clk);
            rst = 0;
            if (!which) begin
                a_iack = tr[k].iack; a_dack = tr[k].dack; a_eq = tr[k].eq; a_instr = tr[k].instr;
            end else begin
                b_iack = tr[k].iack; b_dack = tr[k].dack; b_eq = tr[k].eq; b_instr = tr[k].instr;
            end
            #1;
            if (k == 0) chk({tag, "_ret"}, which ? 32'(b_ret) : 32'(a_ret), which ? 32'(ret_b) : 32'(ret_a));
            chk($sformatf("%s_c%0d", tag, k), which ? 32'(ob) : 32'(oa), 32'(tr[k].exp));
        end
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1; a_iack = 0; a_dack = 0; b_iack = 0; b_dack = 0;
        @(negedge clk); #1;
        chk({tag, "_a"}, 32'(oa), 32'(pk(1,0,0,0,0,0,A_NOP,0,O_NOP,D_NOP,0)));
        chk({tag, "_b"}, 32'(ob), 32'(pk(1,0,0,0,0,0,A_NOP,0,O_NOP,D_NOP,0)));
        chk({tag, "_reta"}, 32'(a_ret), 0);
        chk({tag, "_retb"}, 32'(b_ret), 0);
        ret_a = '0; ret_b = '0;
    endtask

    task automatic run(input bit which, input logic [1:0] op, input logic [2:0] fn,
                       input int wi, input int wd, input logic eq, input string tag);
        bit r, t;
        build(op, fn, wi, wd, eq, !which, r, t);
        play(which, 1000, tag);
        if (r) begin
            if (which) ret_b = ret_b + 1'b1; else ret_a = ret_a + 1'b1;
        end
        if (t) do_reset({tag, "_rst"});
    endtask

    initial begin
        bit r, t;
        do_reset("por");
        // non-trapping illegal policy
        run(1, 2'b01, 3'b010, 0, 0, 0, "b_ill");
        run(1, 2'b00, 3'd0, 2, 0, 0, "b_add");
        do_reset("rst_b");
        // directed on trapping instance
        run(0, 2'b00, 3'd0, 0, 0, 0, "add");
        run(0, 2'b01, 3'd1, 0, 3, 0, "load_w3");
        run(0, 2'b11, 3'd5, 0, 0, 1, "beq_t");
        run(0, 2'b11, 3'd2, 1, 0, 0, "beq_f");
        run(0, 2'b01, 3'd3, 0, 0, 0, "stor");
        run(0, 2'b10, 3'd7, 0, 0, 0, "jal");
        run(0, 2'b01, 3'd4, 0, 0, 0, "lui");
        run(0, 2'b01, 3'd0, 0, 0, 0, "addi");
        run(0, 2'b00, 3'd4, 0, 0, 0, "slt");
        run(0, 2'b00, 3'd1, TMO - 1, 0, 0, "fetch_edge");
        run(0, 2'b01, 3'd1, 0, TMO, 0, "mem_edge");
        for (int i = 0; i < 7; i++) run(0, 2'b00, 3'd3, 0, 0, 0, "wrap");
        run(0, 2'b00, 3'd2, 0, 0, 0, "post_wrap");
        run(0, 2'b01, 3'b010, 0, 0, 0, "ill_trap");
        run(0, 2'b00, 3'd0, TMO + 3, 0, 0, "ifetch_to");
        run(0, 2'b01, 3'd3, 0, TMO + 2, 0, "dmem_to");
        // reset in the middle of a data-memory wait
        build(2'b01, 3'd1, 0, 6, 0, 1, r, t);
        play(0, 5, "midmem");
        do_reset("midmem_rst");
        for (int i = 0; i < 80; i++) begin
            int sel, wi, wd;
            logic [1:0] op;
            logic [2:0] fn;
            sel = $urandom_range(0, 19);
            op = 2'($urandom); fn = 3'($urandom);
            wi = ($urandom_range(0, 7) == 0) ? TMO - 1 : $urandom_range(0, 3);
            wd = ($urandom_range(0, 7) == 0) ? TMO : $urandom_range(0, 3);
            if (sel == 0) wi = TMO + 1;
            if (sel == 1) wd = TMO + 1;
            if (sel > 2 && op == 2'b01 && fn == 3'b010) fn = 3'b001;
            run(0, op, fn, wi, wd, 1'($urandom), "rnd");
        end
        @(negedge clk); #1;
        chk("final_ret", 32'(a_ret), 32'(ret_a));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
